// File: rtl/dw02_mac.sv
// Multiply-accumulate core: MAC = A*B + C (mod 2^N), unsigned or two's complement,
// built from a Baugh-Wooley partial-product array, a carry-save chain and one final adder.
module dw02_mac #(
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int OUT_REG = 0
) (
    input  logic                       MAC_ACC_CLK,
    input  logic                       acc_ff_rstn,
    input  logic [A_width-1:0]         A,
    input  logic [B_width-1:0]         B,
    input  logic [A_width+B_width-1:0] C,
    input  logic                       TC,
    output logic [A_width+B_width-1:0] MAC
);

    localparam int N    = A_width + B_width;
    localparam int ROWS = B_width + 2;

    // Baugh-Wooley correction 2^(A_width-1) + 2^(B_width-1) + 2^(N-1), only added when TC=1.
    localparam logic [N-1:0] ONE      = 1;
    localparam logic [N-1:0] BW_CONST = (ONE << (A_width - 1)) + (ONE << (B_width - 1))
                                      + (ONE << (N - 1));

    logic [N-1:0] pp    [ROWS];
    logic [N-1:0] csa_s [ROWS-1];
    logic [N-1:0] csa_c [ROWS-1];
    logic [N-1:0] maj;
    logic [N-1:0] mac_comb;

    always_comb begin
        // Bits pairing exactly one sign bit with a non-sign bit carry negative
        // weight in two's complement; inverting them is the Baugh-Wooley trick.
        for (int j = 0; j < B_width; j++) begin
            pp[j] = '0;
            for (int i = 0; i < A_width; i++) begin
                pp[j][i+j] = (A[i] & B[j]) ^ (TC & ((i == A_width - 1) != (j == B_width - 1)));
            end
        end
        pp[B_width]     = TC ? BW_CONST : '0;
        pp[B_width + 1] = C;

        // Linear 3:2 compressor chain; carries out of bit N-1 are dropped (wrap-around).
        csa_s[0] = pp[0];
        csa_c[0] = pp[1];
        maj      = '0;
        for (int k = 2; k < ROWS; k++) begin
            csa_s[k-1] = csa_s[k-2] ^ csa_c[k-2] ^ pp[k];
            maj        = (csa_s[k-2] & csa_c[k-2]) | (csa_s[k-2] & pp[k]) | (csa_c[k-2] & pp[k]);
            csa_c[k-1] = {maj[N-2:0], 1'b0};
        end

        mac_comb = csa_s[ROWS-2] + csa_c[ROWS-2];
    end

    if (OUT_REG != 0) begin : g_reg
        // No handshake: inputs are sampled on every rising edge; reset clears asynchronously.
        always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
            if (!acc_ff_rstn) begin
                MAC <= '0;
            end else begin
                MAC <= mac_comb;
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = MAC_ACC_CLK ^ acc_ff_rstn;
        assign MAC            = mac_comb;
    end

endmodule

// File: tb/tb_dw02_mac.sv
// Bench for dw02_mac at 12x12: directed vectors on combinational and registered
// instances, then random vectors against a behavioural multiply model.
module tb_dw02_mac;

    localparam int AW = 12;
    localparam int BW = 12;
    localparam int NW = AW + BW;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [NW-1:0] c;
    logic          tc;
    logic [NW-1:0] mac_c;
    logic [NW-1:0] mac_r;

    int n_checks;
    int n_fail;

    dw02_mac #(.A_width(AW), .B_width(BW), .OUT_REG(0)) u_comb (
        .MAC_ACC_CLK (clk),
        .acc_ff_rstn (rstn),
        .A           (a),
        .B           (b),
        .C           (c),
        .TC          (tc),
        .MAC         (mac_c)
    );

    dw02_mac #(.A_width(AW), .B_width(BW), .OUT_REG(1)) u_reg (
        .MAC_ACC_CLK (clk),
        .acc_ff_rstn (rstn),
        .A           (a),
        .B           (b),
        .C           (c),
        .TC          (tc),
        .MAC         (mac_r)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply at the falling edge, settle 1 time unit
    task automatic drive(input logic [AW-1:0] va, input logic [BW-1:0] vb,
                         input logic [NW-1:0] vc, input logic vtc);
        @(negedge clk);
        a  = va;
        b  = vb;
        c  = vc;
        tc = vtc;
        #1;
    endtask

    function automatic logic [NW-1:0] model(input logic [AW-1:0] ma, input logic [BW-1:0] mb,
                                            input logic [NW-1:0] mc, input logic mtc);
        logic [NW-1:0] ea;
        logic [NW-1:0] eb;
        ea = mtc ? {{(NW-AW){ma[AW-1]}}, ma} : {{(NW-AW){1'b0}}, ma};
        eb = mtc ? {{(NW-BW){mb[BW-1]}}, mb} : {{(NW-BW){1'b0}}, mb};
        return NW'(ea * eb + mc);
    endfunction

    task automatic test_reset();
        #1;
        n_checks++;
        if (mac_r !== 24'h000000) begin
            $display("FAIL reset_value: got %h expected %h", mac_r, 24'h000000);
            n_fail++;
        end
    endtask

    task automatic test_unsigned();
        drive(12'h0FF, 12'h0FF, 24'h000000, 1'b0);
        n_checks++;
        if (mac_c !== 24'h00FE01) begin
            $display("FAIL unsigned_full_scale: got %h expected %h", mac_c, 24'h00FE01);
            n_fail++;
        end
    endtask

    task automatic test_signed_min();
        drive(12'hF80, 12'hF80, 24'h000000, 1'b1);
        n_checks++;
        if (mac_c !== 24'h004000) begin
            $display("FAIL signed_f80_sq: got %h expected %h", mac_c, 24'h004000);
            n_fail++;
        end
        drive(12'h800, 12'h800, 24'h000000, 1'b1);
        n_checks++;
        if (mac_c !== 24'h400000) begin
            $display("FAIL signed_most_neg_sq: got %h expected %h", mac_c, 24'h400000);
            n_fail++;
        end
    endtask

    task automatic test_accumulate();
        drive(12'h003, 12'h004, 24'h000010, 1'b0);
        n_checks++;
        if (mac_c !== 24'h00001C) begin
            $display("FAIL accumulate: got %h expected %h", mac_c, 24'h00001C);
            n_fail++;
        end
        drive(12'hFFE, 12'h003, 24'h000007, 1'b1);  // -2*3 + 7 = 1
        n_checks++;
        if (mac_c !== 24'h000001) begin
            $display("FAIL accumulate_signed: got %h expected %h", mac_c, 24'h000001);
            n_fail++;
        end
    endtask

    task automatic test_sign_sensitivity();
        drive(12'hFFF, 12'h001, 24'h000000, 1'b1);
        n_checks++;
        if (mac_c !== 24'hFFFFFF) begin
            $display("FAIL sign_tc1: got %h expected %h", mac_c, 24'hFFFFFF);
            n_fail++;
        end
        drive(12'hFFF, 12'h001, 24'h000000, 1'b0);
        n_checks++;
        if (mac_c !== 24'h000FFF) begin
            $display("FAIL sign_tc0: got %h expected %h", mac_c, 24'h000FFF);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        drive(12'hFFF, 12'hFFF, 24'h002000, 1'b0);
        n_checks++;
        if (mac_c !== 24'h000001) begin
            $display("FAIL wrap_unsigned: got %h expected %h", mac_c, 24'h000001);
            n_fail++;
        end
        drive(12'h7FF, 12'h7FF, 24'hFFFFFF, 1'b1);
        n_checks++;
        if (mac_c !== 24'h3FF000) begin
            $display("FAIL wrap_signed: got %h expected %h", mac_c, 24'h3FF000);
            n_fail++;
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rstn = 1'b1;
        a = 12'h003; b = 12'h004; c = 24'h000000; tc = 1'b0;
        #1;
        n_checks++;
        if (mac_r !== 24'h000000) begin
            $display("FAIL reg_before_edge: got %h expected %h", mac_r, 24'h000000);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mac_r !== 24'h00000C) begin
            $display("FAIL reg_first_edge: got %h expected %h", mac_r, 24'h00000C);
            n_fail++;
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (mac_r !== 24'h000000) begin
            $display("FAIL reg_async_clear: got %h expected %h", mac_r, 24'h000000);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (mac_r !== 24'h000000) begin
            $display("FAIL reg_held_in_reset: got %h expected %h", mac_r, 24'h000000);
            n_fail++;
        end
        @(negedge clk);
        rstn = 1'b1;
        a = 12'h005; b = 12'h006; c = 24'h000001;
        @(posedge clk);
        #1;
        n_checks++;
        if (mac_r !== 24'h00001F) begin
            $display("FAIL reg_after_release: got %h expected %h", mac_r, 24'h00001F);
            n_fail++;
        end
    endtask

    task automatic test_random(input int count);
        logic [NW-1:0] exp_v;
        for (int n = 0; n < count; n++) begin
            drive(AW'($urandom_range(0, 4095)), BW'($urandom_range(0, 4095)),
                  NW'($urandom()), 1'($urandom_range(0, 1)));
            exp_v = model(a, b, c, tc);
            n_checks++;
            if (mac_c !== exp_v) begin
                $display("FAIL rand_comb a=%h b=%h c=%h tc=%b: got %h expected %h",
                         a, b, c, tc, mac_c, exp_v);
                n_fail++;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (mac_r !== exp_v) begin
                $display("FAIL rand_reg a=%h b=%h c=%h tc=%b: got %h expected %h",
                         a, b, c, tc, mac_r, exp_v);
                n_fail++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        tc       = 1'b0;

        test_reset();
        test_unsigned();
        test_signed_min();
        test_accumulate();
        test_sign_sensitivity();
        test_wrap();
        test_registered();
        test_random(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
